// File: rtl/jtag_bridge_pkg.sv
// Shared types and status-word bit offsets for the JTAG-to-register-bus bridge.
package jtag_bridge_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StReq  = 1'b1
  } bridge_state_e;

  // Status flag positions, counted upward from DATA_W inside the captured word.
  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_ERR  = 1;
  localparam int unsigned ST_OVR  = 2;

endpackage

// File: rtl/jtag_dr_shifter.sv
// JTAG data register: parallel capture, LSB-first shift, and a falling-edge TDO flop.
module jtag_dr_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sel_i,
  input  logic             capture_i,
  input  logic             shift_i,
  input  logic             tdi_i,
  input  logic [WIDTH-1:0] capture_data_i,
  output logic [WIDTH-1:0] dr_o,
  output logic             tdo_o
);

  logic [WIDTH-1:0] dr_d, dr_q;
  logic             tdo_q;

  // Capture has priority over shift when both strobes are seen together.
  always_comb begin
    dr_d = dr_q;
    if (sel_i && capture_i) begin
      dr_d = capture_data_i;
    end else if (sel_i && shift_i) begin
      dr_d = {tdi_i, dr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dr_q <= '0;
    end else begin
      dr_q <= dr_d;
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= dr_q[0];
    end
  end

  assign dr_o  = dr_q;
  assign tdo_o = tdo_q;

endmodule

// File: rtl/jtag_reg_bridge.sv
// USER1 data register to single-outstanding req/ack register-bus master, clocked by TCK.
module jtag_reg_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              tckutap,
  input  logic              reset,
  input  logic              sel,
  input  logic              captureuser,
  input  logic              shiftuser,
  input  logic              updateuser,
  input  logic              tdiutap,
  output logic              tdo,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned DR_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CntW = $clog2(TIMEOUT);

  bridge_state_e state_d, state_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              done_d, done_q;
  logic              err_d, err_q;
  logic              ovr_d, ovr_q;
  logic [CntW-1:0]   cnt_d, cnt_q;

  logic [DR_W-1:0] dr;
  logic [DR_W-1:0] status;
  logic            upd;

  assign upd = sel & updateuser;

  always_comb begin
    status                       = '0;
    status[DR_W-1]               = (state_q == StReq);
    status[DATA_W + ST_DONE]     = done_q;
    status[DATA_W + ST_ERR]      = err_q;
    status[DATA_W + ST_OVR]      = ovr_q;
    status[DATA_W-1:0]           = rdata_q;
  end

  jtag_dr_shifter #(
    .WIDTH(DR_W)
  ) u_dr (
    .clk_i         (tckutap),
    .rst_i         (reset),
    .sel_i         (sel),
    .capture_i     (captureuser),
    .shift_i       (shiftuser),
    .tdi_i         (tdiutap),
    .capture_data_i(status),
    .dr_o          (dr),
    .tdo_o         (tdo)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = done_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (upd) begin
          we_d    = dr[DR_W-1];
          addr_d  = dr[DATA_W +: ADDR_W];
          wdata_d = dr[DATA_W-1:0];
          done_d  = 1'b0;
          err_d   = 1'b0;
          ovr_d   = 1'b0;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus_ack) begin
          if (!we_q) begin
            rdata_d = bus_rdata;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // A new command while one is in flight is discarded, even on the ack cycle.
        if (upd) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge tckutap or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_req   = (state_q == StReq);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Scoreboard bench: stimulus queues expected bus requests and captured status words.
module tb_jtag_reg_bridge;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DR_W    = 1 + ADDR_W + DATA_W;

  logic              tckutap = 1'b0;
  logic              reset = 1'b1;
  logic              sel = 1'b0;
  logic              captureuser = 1'b0;
  logic              shiftuser = 1'b0;
  logic              updateuser = 1'b0;
  logic              tdiutap = 1'b0;
  logic              tdo;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  int          ack_delay = 0;
  logic [15:0] rd_val = 16'h0000;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          len;
  } bus_exp_t;

  bus_exp_t        bus_q[$];
  logic [DR_W-1:0] st_q[$];
  logic [DR_W-1:0] cap_word;
  event            cap_ev;

  jtag_reg_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .tckutap    (tckutap),
    .reset      (reset),
    .sel        (sel),
    .captureuser(captureuser),
    .shiftuser  (shiftuser),
    .updateuser (updateuser),
    .tdiutap    (tdiutap),
    .tdo        (tdo),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  always #5 tckutap = ~tckutap;

  assign bus_rdata = bus_ack ? rd_val : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DR_W-1:0] st(input bit busy, input bit ovr, input bit err,
                                         input bit done, input logic [15:0] rd);
    return {busy, 5'b00000, ovr, err, done, rd};
  endfunction

  task automatic exp_bus(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                         input int len);
    bus_exp_t e;
    e.we = we;
    e.addr = addr;
    e.wdata = wdata;
    e.len = len;
    bus_q.push_back(e);
  endtask

  // Bus responder: acks on the ack_delay-th cycle of a request; 0 means never.
  int rcnt = 0;
  initial begin
    forever begin
      @(negedge tckutap);
      if (bus_req) rcnt++;
      else rcnt = 0;
      #1 bus_ack = (rcnt != 0) && (ack_delay != 0) && (rcnt == ack_delay);
    end
  end

  // Bus monitor: records each request and scores it when bus_req falls.
  int          m_len = 0;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic        m_stable;
  initial begin
    bus_exp_t e;
    forever begin
      @(negedge tckutap);
      if (bus_req) begin
        if (m_len == 0) begin
          m_we = bus_we;
          m_addr = bus_addr;
          m_wdata = bus_wdata;
          m_stable = 1'b1;
        end else if ({bus_we, bus_addr, bus_wdata} != {m_we, m_addr, m_wdata}) begin
          m_stable = 1'b0;
        end
        m_len++;
      end else if (m_len != 0) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %0h len %0d, expected no request", m_addr,
                   m_len);
        end else begin
          e = bus_q.pop_front();
          check("req_we", {31'b0, m_we}, {31'b0, e.we});
          check("req_addr", {24'b0, m_addr}, {24'b0, e.addr});
          check("req_wdata", {16'b0, m_wdata}, {16'b0, e.wdata});
          check("req_len", m_len, e.len);
          check("req_stable", {31'b0, m_stable}, 32'd1);
        end
        m_len = 0;
      end
    end
  end

  // Status monitor: scores each word read back through tdo.
  initial begin
    forever begin
      @(cap_ev);
      if (st_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_status: got %0h, expected nothing queued", cap_word);
      end else begin
        check("status_word", {7'b0, cap_word}, {7'b0, st_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(negedge tckutap);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Optional capture, DR_W shifts collecting tdo, optional update pulse.
  task automatic scan(input logic [DR_W-1:0] din, input bit do_cap, input bit do_upd);
    logic [DR_W-1:0] dout;
    if (do_cap) begin
      tick();
      captureuser = 1'b1;
    end
    for (int i = 0; i < DR_W; i++) begin
      tick();
      dout[i] = tdo;
      captureuser = 1'b0;
      shiftuser = 1'b1;
      tdiutap = din[i];
    end
    tick();
    shiftuser = 1'b0;
    updateuser = do_upd;
    tick();
    updateuser = 1'b0;
    cap_word = dout;
    ->cap_ev;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DR_W-1:0] x;
    x = {1'b1, 8'h3C, 16'hC0DE};

    idle(2);
    check("rst_req", {31'b0, bus_req}, 32'd0);
    check("rst_we", {31'b0, bus_we}, 32'd0);
    check("rst_addr", {24'b0, bus_addr}, 32'd0);
    check("rst_wdata", {16'b0, bus_wdata}, 32'd0);
    check("rst_tdo", {31'b0, tdo}, 32'd0);
    reset = 1'b0;
    sel = 1'b1;
    idle(2);

    // Write, acked on cycle 3.
    ack_delay = 3;
    rd_val = 16'hFFFF;
    st_q.push_back(st(0, 0, 0, 0, 16'h0000));
    exp_bus(1'b1, 8'h12, 16'hBEEF, 3);
    scan({1'b1, 8'h12, 16'hBEEF}, 1, 1);
    idle(20);

    // Read, acked on cycle 1.
    ack_delay = 1;
    rd_val = 16'h1234;
    st_q.push_back(st(0, 0, 0, 1, 16'h0000));
    exp_bus(1'b0, 8'h05, 16'h0000, 1);
    scan({1'b0, 8'h05, 16'h0000}, 1, 1);
    idle(20);

    // Read that times out.
    ack_delay = 0;
    st_q.push_back(st(0, 0, 0, 1, 16'h1234));
    exp_bus(1'b0, 8'h07, 16'h0000, TIMEOUT);
    scan({1'b0, 8'h07, 16'h0000}, 1, 1);
    idle(20);

    // Write with a second update while in flight.
    ack_delay = 5;
    rd_val = 16'hFFFF;
    st_q.push_back(st(0, 0, 1, 0, 16'h1234));
    exp_bus(1'b1, 8'h21, 16'h5555, 5);
    scan({1'b1, 8'h21, 16'h5555}, 1, 1);
    tick();
    updateuser = 1'b1;
    tick();
    updateuser = 1'b0;
    idle(20);

    // Next accepted command reports and then clears the overrun.
    ack_delay = 2;
    rd_val = 16'hA5C3;
    st_q.push_back(st(0, 1, 0, 1, 16'h1234));
    exp_bus(1'b0, 8'h30, 16'h0000, 2);
    scan({1'b0, 8'h30, 16'h0000}, 1, 1);
    idle(20);
    st_q.push_back(st(0, 0, 0, 1, 16'hA5C3));
    scan('0, 1, 0);
    idle(5);

    // Capture while a request is still pending shows busy.
    ack_delay = 0;
    st_q.push_back(st(0, 0, 0, 1, 16'hA5C3));
    exp_bus(1'b0, 8'h44, 16'h0000, TIMEOUT);
    scan({1'b0, 8'h44, 16'h0000}, 1, 1);
    st_q.push_back(st(1, 0, 0, 0, 16'hA5C3));
    scan('0, 1, 0);
    idle(20);

    // Reset in the middle of a request.
    st_q.push_back(st(0, 0, 1, 0, 16'hA5C3));
    exp_bus(1'b1, 8'h0F, 16'h0F0F, 4);
    scan({1'b1, 8'h0F, 16'h0F0F}, 1, 1);
    idle(3);
    reset = 1'b1;
    #1;
    check("req_async_reset", {31'b0, bus_req}, 32'd0);
    tick();
    reset = 1'b0;
    idle(2);
    st_q.push_back(st(0, 0, 0, 0, 16'h0000));
    scan(x, 1, 0);
    idle(3);

    // Deselected chain ignores every strobe.
    sel = 1'b0;
    tick();
    captureuser = 1'b1;
    tick();
    captureuser = 1'b0;
    shiftuser = 1'b1;
    tdiutap = 1'b0;
    idle(4);
    shiftuser = 1'b0;
    updateuser = 1'b1;
    tick();
    updateuser = 1'b0;
    idle(3);
    check("nosel_req", {31'b0, bus_req}, 32'd0);
    check("nosel_we", {31'b0, bus_we}, 32'd0);
    check("nosel_addr", {24'b0, bus_addr}, 32'd0);
    check("nosel_wdata", {16'b0, bus_wdata}, 32'd0);
    sel = 1'b1;
    st_q.push_back(x);
    scan('0, 0, 0);
    idle(5);

    check("bus_q_empty", bus_q.size(), 32'd0);
    check("st_q_empty", st_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
